// File: rtl/rsa_loader_pkg.sv
// ---------------------------------------------------------------------------
// rsa_loader_pkg : shared types and defaults for the RSA block loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rsa_loader_pkg;

    localparam int DEF_DATA_WIDTH      = 16;
    localparam int DEF_WORDS_PER_BLOCK = 16;
    localparam int BLOCKS_DONE_W       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LAUNCH = 2'd2,
        RUN    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/block_word_assembler.sv
// ---------------------------------------------------------------------------
// block_word_assembler : packs FIFO words MSB-first into one operand block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module block_word_assembler
    import rsa_loader_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int CNT_W           = $clog2(WORDS_PER_BLOCK + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear_i,
    input  logic                                  capture_i,
    input  logic                                  pad_i,
    input  logic [DATA_WIDTH-1:0]                 word_i,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] block_o,
    output logic [CNT_W-1:0]                      captured_o
);

    localparam int BLOCK_W = DATA_WIDTH * WORDS_PER_BLOCK;

    logic [BLOCK_W-1:0] block_q, block_d;
    logic [CNT_W-1:0]   captured_q, captured_d;
    logic [31:0]        pad_bits;

    // Left-justify a partial block so the first word stays in the top slice.
    assign pad_bits = (32'(WORDS_PER_BLOCK) - 32'(captured_q)) * 32'(DATA_WIDTH);

    always_comb begin
        block_d    = block_q;
        captured_d = captured_q;
        if (clear_i) begin
            captured_d = '0;
        end else if (capture_i) begin
            block_d    = {block_q[BLOCK_W-DATA_WIDTH-1:0], word_i};
            captured_d = captured_q + CNT_W'(1);
        end else if (pad_i) begin
            block_d = block_q << pad_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            block_q    <= '0;
            captured_q <= '0;
        end else begin
            block_q    <= block_d;
            captured_q <= captured_d;
        end
    end

    assign block_o    = block_q;
    assign captured_o = captured_q;

endmodule

`default_nettype wire

// File: rtl/rsa_block_loader.sv
// ---------------------------------------------------------------------------
// rsa_block_loader : FIFO-to-RSA-core block sequencer (optional RSA_LOADER_FLUSH_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rsa_block_loader
    import rsa_loader_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int CNT_W           = $clog2(WORDS_PER_BLOCK + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
`ifdef RSA_LOADER_FLUSH_EN
    input  logic                                  flush,
`endif
    input  logic                                  fifo_empty,
    input  logic [DATA_WIDTH-1:0]                 fifo_data,
    output logic                                  fifo_rd_en,
    input  logic                                  core_ready,
    output logic                                  core_start,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] core_block,
    input  logic                                  core_done,
    output logic                                  busy,
    output logic [BLOCKS_DONE_W-1:0]              blocks_done
);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         issued_q, issued_d;
    logic                     rd_pending_q;
    logic [BLOCKS_DONE_W-1:0] blocks_done_q, blocks_done_d;
    logic [CNT_W-1:0]         captured;
    logic                     asm_clear;
    logic                     asm_pad;
    logic                     flush_stop;

`ifdef RSA_LOADER_FLUSH_EN
    assign flush_stop = flush && (issued_q != '0);
`else
    assign flush_stop = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        core_start = 1'b0;
        asm_clear  = 1'b0;
        asm_pad    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = FETCH;
                    asm_clear = 1'b1;
                end
            end
            FETCH: begin
                fifo_rd_en = !fifo_empty && (issued_q < CNT_W'(WORDS_PER_BLOCK)) && !flush_stop;
                if (rd_pending_q && (captured == CNT_W'(WORDS_PER_BLOCK - 1))) begin
                    state_d = LAUNCH;
                end else if (flush_stop && !rd_pending_q) begin
                    // Flush waits for the in-flight word so it is kept in the block.
                    asm_pad = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (core_ready) begin
                    core_start = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_d   = en ? FETCH : IDLE;
                    asm_clear = en;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issued_d      = issued_q;
        blocks_done_d = blocks_done_q;
        if (asm_clear) begin
            issued_d = '0;
        end else if (fifo_rd_en) begin
            issued_d = issued_q + CNT_W'(1);
        end
        if ((state_q == RUN) && core_done) begin
            blocks_done_d = blocks_done_q + BLOCKS_DONE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            issued_q      <= '0;
            rd_pending_q  <= 1'b0;
            blocks_done_q <= '0;
        end else begin
            state_q       <= state_d;
            issued_q      <= issued_d;
            rd_pending_q  <= fifo_rd_en;
            blocks_done_q <= blocks_done_d;
        end
    end

    block_word_assembler #(
        .DATA_WIDTH      (DATA_WIDTH),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .CNT_W           (CNT_W)
    ) u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (asm_clear),
        .capture_i  (rd_pending_q),
        .pad_i      (asm_pad),
        .word_i     (fifo_data),
        .block_o    (core_block),
        .captured_o (captured)
    );

    assign busy        = (state_q != IDLE);
    assign blocks_done = blocks_done_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_block_loader.sv
// ---------------------------------------------------------------------------
// tb_rsa_block_loader : directed table-driven bench with a small FIFO model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rsa_block_loader;

    localparam int DW  = 16;
    localparam int WPB = 16;
    localparam int BW  = DW * WPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          core_ready;
    logic          core_done;
`ifdef RSA_LOADER_FLUSH_EN
    logic          flush;
`endif
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          core_start;
    logic [BW-1:0] core_block;
    logic          busy;
    logic [15:0]   blocks_done;

    rsa_block_loader #(
        .DATA_WIDTH      (DW),
        .WORDS_PER_BLOCK (WPB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
`ifdef RSA_LOADER_FLUSH_EN
        .flush       (flush),
`endif
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd_en  (fifo_rd_en),
        .core_ready  (core_ready),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_done   (core_done),
        .busy        (busy),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after a read; empty is real-time.
    logic [DW-1:0] mem [0:255];
    int pushed_cnt = 0;
    int popped_cnt = 0;
    assign fifo_empty = (pushed_cnt == popped_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data  <= mem[popped_cnt % 256];
            popped_cnt <= popped_cnt + 1;
        end
    end

    typedef struct {
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        int            ready_delay;
        logic [BW-1:0] exp_block;
        int            exp_start;
    } vec_t;

    vec_t vecs [3];

    int            checks = 0;
    int            errors = 0;
    int            exp_blocks = 0;
    int            rd_total = 0;
    int            start_total = 0;
    int            rd_empty_viol = 0;
    logic          smp_rd;
    logic          smp_start;
    logic          smp_busy;
    logic [BW-1:0] smp_block;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[pushed_cnt % 256] = w;
        pushed_cnt++;
    endtask

    // Called at a negedge after inputs are driven; samples this cycle, moves to next negedge.
    task automatic step();
        #1;
        smp_rd    = fifo_rd_en;
        smp_start = core_start;
        smp_busy  = busy;
        smp_block = core_block;
        if (fifo_rd_en) rd_total++;
        if (core_start) start_total++;
        if (fifo_rd_en && fifo_empty) rd_empty_viol++;
        @(negedge clk);
    endtask

    task automatic wait_start(input int limit, output int cyc_seen);
        cyc_seen = -1;
        for (int c = 0; c < limit; c++) begin
            step();
            if (smp_start) begin
                cyc_seen = c;
                break;
            end
        end
    endtask

    task automatic finish_block();
        core_ready = 1'b0;
        en         = 1'b0;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        exp_blocks++;
    endtask

    task automatic run_vector(input int idx);
        vec_t          v;
        int            rd0;
        int            st0;
        int            start_cyc;
        logic [BW-1:0] blk_launch;
        logic [BW-1:0] blk_start;
        v = vecs[idx];
        for (int i = 0; i < WPB; i++) push(v.base + v.step * DW'(i));
        core_ready = (v.ready_delay == 0);
        en         = 1'b1;
        step();
        rd0        = rd_total;
        st0        = start_total;
        start_cyc  = -1;
        blk_launch = '0;
        blk_start  = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == WPB + 1 + v.ready_delay) core_ready = 1'b1;
            if (start_cyc >= 0) begin
                core_ready = 1'b0;
                en         = 1'b0;
            end
            step();
            if (cyc == WPB + 1) blk_launch = smp_block;
            if (smp_start && start_cyc < 0) begin
                start_cyc = cyc;
                blk_start = smp_block;
            end
        end
        chk($sformatf("v%0d_rd_count", idx), rd_total - rd0, WPB);
        chk($sformatf("v%0d_start_cycle", idx), start_cyc, v.exp_start);
        chk($sformatf("v%0d_start_pulses", idx), start_total - st0, 1);
        chk($sformatf("v%0d_launch_block", idx), blk_launch, v.exp_block);
        chk($sformatf("v%0d_start_block", idx), blk_start, v.exp_block);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        exp_blocks++;
        chk($sformatf("v%0d_blocks_done", idx), blocks_done, exp_blocks);
        chk($sformatf("v%0d_busy_idle", idx), busy, 0);
    endtask

    initial begin
        int rd0;
        int st0;
        int sc;

        vecs[0] = '{16'h0001, 16'h0001, 0,
            256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010, 17};
        vecs[1] = '{16'ha000, 16'h0001, 5,
            256'ha000_a001_a002_a003_a004_a005_a006_a007_a008_a009_a00a_a00b_a00c_a00d_a00e_a00f, 22};
        vecs[2] = '{16'hf000, 16'h0011, 2,
            256'hf000_f011_f022_f033_f044_f055_f066_f077_f088_f099_f0aa_f0bb_f0cc_f0dd_f0ee_f0ff, 19};

        rst_n      = 1'b0;
        en         = 1'b0;
        core_ready = 1'b0;
        core_done  = 1'b0;
`ifdef RSA_LOADER_FLUSH_EN
        flush      = 1'b0;
`endif
        @(negedge clk);
        step();
        step();
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_block", core_block, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blocks_done", blocks_done, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 3; i++) run_vector(i);

        // FIFO runs dry after 7 words; 9 more arrive 20 cycles later.
        for (int i = 0; i < 7; i++) push(16'h1001 + DW'(i));
        core_ready = 1'b1;
        en         = 1'b1;
        step();
        rd0 = rd_total;
        st0 = start_total;
        sc  = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc == 27) for (int i = 7; i < 16; i++) push(16'h1001 + DW'(i));
            step();
            if (cyc == 26) begin
                chk("gap_rd_paused", rd_total - rd0, 7);
                chk("gap_no_start", start_total - st0, 0);
                chk("gap_busy", smp_busy, 1);
            end
            if (smp_start) begin
                sc = cyc;
                break;
            end
        end
        chk("gap_start_cycle", sc, 37);
        chk("gap_block", smp_block,
            256'h1001_1002_1003_1004_1005_1006_1007_1008_1009_100a_100b_100c_100d_100e_100f_1010);
        chk("gap_rd_total", rd_total - rd0, 16);
        finish_block();

        // Two blocks back-to-back; en dropped during the second RUN.
        for (int i = 0; i < 16; i++) push(16'h2000 + DW'(i));
        for (int i = 0; i < 16; i++) push(16'h3000 + DW'(i));
        core_ready = 1'b1;
        en         = 1'b1;
        step();
        wait_start(40, sc);
        chk("b2b_first_start", sc, 17);
        chk("b2b_first_block", smp_block,
            256'h2000_2001_2002_2003_2004_2005_2006_2007_2008_2009_200a_200b_200c_200d_200e_200f);
        core_ready = 1'b0;
        step();
        step();
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        exp_blocks++;
        rd0 = rd_total;
        step();
        chk("b2b_refetch_rd", smp_rd, 1);
        core_ready = 1'b1;
        wait_start(40, sc);
        chk("b2b_second_start", sc, 16);
        chk("b2b_second_block", smp_block,
            256'h3000_3001_3002_3003_3004_3005_3006_3007_3008_3009_300a_300b_300c_300d_300e_300f);
        chk("b2b_second_rd", rd_total - rd0, 16);
        core_ready = 1'b0;
        step();
        en = 1'b0;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        exp_blocks++;
        push(16'h7777);
        push(16'h8888);
        rd0 = rd_total;
        repeat (10) step();
        chk("b2b_no_rd_after", rd_total - rd0, 0);
        chk("b2b_idle", busy, 0);
        chk("b2b_blocks_done", blocks_done, exp_blocks);

        // Reset after five captures, then a clean block from count 0.
        pushed_cnt = popped_cnt;
        for (int i = 0; i < 16; i++) push(16'h4000 + DW'(i));
        core_ready = 1'b0;
        en         = 1'b1;
        step();
        repeat (6) step();
        rst_n = 1'b0;
        en    = 1'b0;
        step();
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_core_block", core_block, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_blocks_done", blocks_done, 0);
        rst_n      = 1'b1;
        exp_blocks = 0;
        pushed_cnt = popped_cnt;
        for (int i = 0; i < 16; i++) push(16'h5000 + DW'(i));
        core_ready = 1'b1;
        en         = 1'b1;
        step();
        rd0 = rd_total;
        wait_start(40, sc);
        chk("post_rst_start", sc, 17);
        chk("post_rst_block", smp_block,
            256'h5000_5001_5002_5003_5004_5005_5006_5007_5008_5009_500a_500b_500c_500d_500e_500f);
        chk("post_rst_rd", rd_total - rd0, 16);
        finish_block();
        chk("post_rst_blocks_done", blocks_done, exp_blocks);

        // core_done while IDLE has no effect.
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        chk("stray_done_count", blocks_done, exp_blocks);
        chk("stray_done_idle", busy, 0);

`ifdef RSA_LOADER_FLUSH_EN
        push(16'haaaa);
        push(16'hbbbb);
        push(16'hcccc);
        core_ready = 1'b1;
        en         = 1'b1;
        step();
        repeat (6) step();
        flush = 1'b1;
        wait_start(10, sc);
        chk("flush_start", sc, 1);
        chk("flush_block", smp_block, {48'haaaa_bbbb_cccc, 208'h0});
        flush = 1'b0;
        finish_block();
        chk("flush_blocks_done", blocks_done, exp_blocks);

        // Flush before any read is issued is ignored.
        flush = 1'b1;
        en    = 1'b1;
        step();
        st0 = start_total;
        repeat (5) step();
        chk("flush_noissue_no_start", start_total - st0, 0);
        chk("flush_noissue_busy", busy, 1);
        flush = 1'b0;
        for (int i = 0; i < 16; i++) push(16'h6000 + DW'(i));
        wait_start(40, sc);
        chk("flush_noissue_block", smp_block,
            256'h6000_6001_6002_6003_6004_6005_6006_6007_6008_6009_600a_600b_600c_600d_600e_600f);
        finish_block();
        chk("flush_noissue_blocks_done", blocks_done, exp_blocks);
`endif

        chk("no_rd_while_empty", rd_empty_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
